// File: rtl/user_lock_pkg.sv
// Shared types and defaults for the owner-locked register arbiter.
package user_lock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] DEF_OWNER_ID = 2'h2;
    localparam int         DEF_DATA_W   = 8;

endpackage

// File: rtl/user_lock_rr_arbiter.sv
// Combinational round-robin picker: search starts one past i_ptr and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/user_lock_arbiter.sv
// Round-robin access to an owner-locked register; only OWNER_ID may write.
// Optional saturating denied-write counter enabled by USER_LOCK_VIOL_CNT_EN.
module user_lock_arbiter
    import user_lock_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         DATA_W   = DEF_DATA_W,
    parameter logic [1:0] OWNER_ID = DEF_OWNER_ID
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2*NUM_REQ-1:0]       usr_id,
    input  logic [DATA_W*NUM_REQ-1:0]  wdata,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy
`ifdef USER_LOCK_VIOL_CNT_EN
    ,
    output logic [7:0]                 viol_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             r_state;
    state_e             w_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_id;
    logic [DATA_W-1:0]  r_data;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;
    logic               w_deny;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx)
    );

    assign w_any     = |w_grant;
    assign w_deny    = (r_state == CHECK) && (r_id != OWNER_ID);
    assign busy      = (r_state != IDLE);
    assign grant_idx = r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = CHECK;
            CHECK:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Winner's ID and data are captured at grant so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= IDX_W'(NUM_REQ - 1);
            r_idx    <= '0;
            r_id     <= '0;
            r_data   <= '0;
            data_out <= '0;
            ack      <= '0;
            err      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx    <= w_win_idx;
                        r_rr_ptr <= w_win_idx;
                        r_id     <= usr_id[2*w_win_idx +: 2];
                        r_data   <= wdata[DATA_W*w_win_idx +: DATA_W];
                    end
                end
                CHECK: begin
                    if (!w_deny) begin
                        data_out   <= r_data;
                        ack[r_idx] <= 1'b1;
                    end else begin
                        err[r_idx] <= 1'b1;
                    end
                end
                DONE: begin
                    ack <= '0;
                    err <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef USER_LOCK_VIOL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            viol_cnt <= '0;
        else if (w_deny && viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_user_lock_arbiter.sv
// Directed bench for user_lock_arbiter; viol_cnt checks follow USER_LOCK_VIOL_CNT_EN.
module tb_user_lock_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      usr_id;
    logic [DATA_W*NUM_REQ-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         data_out;
    logic [1:0]                grant_idx;
    logic                      busy;
`ifdef USER_LOCK_VIOL_CNT_EN
    logic [7:0]                viol_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    user_lock_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OWNER_ID(2'h2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .usr_id    (usr_id),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .data_out  (data_out),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef USER_LOCK_VIOL_CNT_EN
        ,
        .viol_cnt  (viol_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        usr_id = '0;
        wdata  = '0;
        nedge(2);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_gidx", 32'(grant_idx), 32'h0);
`ifdef USER_LOCK_VIOL_CNT_EN
        check("rst_viol", 32'(viol_cnt), 32'h0);
`endif
        rst = 1'b0;

        // Idle quiet period
        for (int i = 0; i < 10; i++) begin
            nedge(1);
            check("idle_acker", {30'h0, |ack, |err}, 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
        end

        // Owner write from requester 1; inputs change after grant
        req[1]       = 1'b1;
        usr_id[3:2]  = 2'h2;
        wdata[15:8]  = 8'hA5;
        nedge(1);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_gidx", 32'(grant_idx), 32'h1);
        check("t2_ack_early", 32'(ack), 32'h0);
        usr_id[3:2]  = 2'h1;
        wdata[15:8]  = 8'hFF;
        nedge(1);
        check("t2_ack", 32'(ack), 32'h2);
        check("t2_err", 32'(err), 32'h0);
        check("t2_data", 32'(data_out), 32'hA5);
        req[1] = 1'b0;
        nedge(1);
        check("t2_ack_clr", 32'(ack), 32'h0);
        check("t2_busy_clr", 32'(busy), 32'h0);
        check("t2_data_hold", 32'(data_out), 32'hA5);

        // Non-owner write from requester 3
        req[3]       = 1'b1;
        usr_id[7:6]  = 2'h1;
        wdata[31:24] = 8'h3C;
        nedge(1);
        check("t3_gidx", 32'(grant_idx), 32'h3);
        nedge(1);
        check("t3_err", 32'(err), 32'h8);
        check("t3_ack", 32'(ack), 32'h0);
        check("t3_data", 32'(data_out), 32'hA5);
`ifdef USER_LOCK_VIOL_CNT_EN
        check("t3_viol", 32'(viol_cnt), 32'h1);
`endif
        req[3] = 1'b0;
        nedge(1);
        check("t3_err_clr", 32'(err), 32'h0);

        // All four request together, data = index
        req    = 4'hF;
        usr_id = 8'b10_10_10_10;
        wdata  = 32'h03_02_01_00;
        for (int k = 0; k < NUM_REQ; k++) begin
            nedge(1);
            check($sformatf("t4_gidx%0d", k), 32'(grant_idx), 32'(k));
            check($sformatf("t4_busy%0d", k), 32'(busy), 32'h1);
            nedge(1);
            check($sformatf("t4_ack%0d", k), 32'(ack), 32'(1 << k));
            check($sformatf("t4_data%0d", k), 32'(data_out), 32'(k));
            req[k] = 1'b0;
            nedge(1);
        end
        check("t4_final", 32'(data_out), 32'h03);
        check("t4_idle", 32'(busy), 32'h0);

        // Reset while in CHECK aborts the write
        req[0]      = 1'b1;
        usr_id[1:0] = 2'h2;
        wdata[7:0]  = 8'h77;
        nedge(1);
        check("t5_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        req = '0;
        #1;
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_data", 32'(data_out), 32'h0);
        nedge(1);
        check("t5_acker", {30'h0, |ack, |err}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nedge(1);
            check("t5_quiet", {30'h0, |ack, |err}, 32'h0);
        end
        req[2]       = 1'b1;
        usr_id[5:4]  = 2'h2;
        wdata[23:16] = 8'h5A;
        nedge(1);
        check("t5_gidx", 32'(grant_idx), 32'h2);
        nedge(1);
        check("t5_ack", 32'(ack), 32'h4);
        check("t5_newdata", 32'(data_out), 32'h5A);
        req[2] = 1'b0;
        nedge(1);

`ifdef USER_LOCK_VIOL_CNT_EN
        // Repeated denied writes saturate the counter
        check("t6_viol0", 32'(viol_cnt), 32'h0);
        req[0]      = 1'b1;
        usr_id[1:0] = 2'h0;
        nedge(3 * 254);
        check("t6_viol254", 32'(viol_cnt), 32'd254);
        nedge(3 * 46);
        req[0] = 1'b0;
        check("t6_viol_sat", 32'(viol_cnt), 32'hFF);
        check("t6_data", 32'(data_out), 32'h5A);
        nedge(3);
        check("t6_viol_hold", 32'(viol_cnt), 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/user_lock_arbiter.md
# user_lock_arbiter

Shares a single owner-locked data register between NUM_REQ requesters. A round-robin arbiter selects one pending write at a time and checks the requester's user ID against the lock owner. Matching writes update the register and are acknowledged; all others are rejected with an error pulse. The block sits between the bus-side requesters and the locked configuration register, replacing direct per-user writes.

## Interface
Parameters:
- NUM_REQ, 4: number of requester ports (2 to 8)
- DATA_W, 8: register width
- OWNER_ID, 2'h2: only user ID permitted to write

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level, held until ack or err
- usr_id  in  2*NUM_REQ  requester i ID at bits [2i+1:2i]
- wdata  in  DATA_W*NUM_REQ  requester i data at bits [DATA_W*i +: DATA_W]
- ack  out  NUM_REQ  one-cycle pulse: write accepted
- err  out  NUM_REQ  one-cycle pulse: write denied (ID mismatch)
- data_out  out  DATA_W  locked register contents
- grant_idx  out  $clog2(NUM_REQ)  index of the latched winner
- busy  out  1  high when not in IDLE
- viol_cnt  out  8  saturating denied-write count (only with USER_LOCK_VIOL_CNT_EN)

## Operation
- FSM states: IDLE, CHECK, DONE.
- IDLE, any req high:
  - latch the winner index, its usr_id and its wdata
  - set rr_ptr to the winner
  - next state CHECK
- IDLE, no req: stay in IDLE.
- CHECK:
  - if latched ID == OWNER_ID: data_out <= latched data; ack[idx] <= 1
  - else: err[idx] <= 1, data_out unchanged
  - next state DONE
- DONE: clear ack and err; next state IDLE. DONE is unconditional.
- Round-robin order: search starts at rr_ptr+1 and wraps modulo NUM_REQ. rr_ptr resets to NUM_REQ-1, so requester 0 wins first after reset.
- Only the winner's inputs are used. Inputs are latched in IDLE, so changes to usr_id or wdata after the grant have no effect.
- ack and err are never high together, and at most one bit of each is set.
- Requester rule: drop req on the clock edge after ack or err is observed. A req still high in IDLE is treated as a new request.
- Reset values:
  - data_out = 0, ack = 0, err = 0, busy = 0
  - grant_idx = 0, viol_cnt = 0
  - state = IDLE, rr_ptr = NUM_REQ-1
- Reset asserted mid-transaction aborts it: no ack or err is issued, and data_out returns to 0.

## Timing
- Edge 0 (IDLE, req seen): inputs latched; busy and grant_idx valid from this edge.
- Edge 1 (CHECK): data_out updated and ack/err set; both visible for exactly one cycle.
- Edge 2 (DONE → IDLE): ack/err cleared; busy falls.
- Back-to-back grants occur every 3 cycles. The earliest next sample is edge 3.
- Simultaneous requests: all remaining requesters are served in round-robin order within NUM_REQ × 3 cycles.

## Configuration
- USER_LOCK_VIOL_CNT_EN defined:
  - viol_cnt port is present
  - it increments by 1 at each CHECK that denies a write
  - it saturates at 8'hFF and clears only on rst
- USER_LOCK_VIOL_CNT_EN undefined: the port and counter logic are absent; all other behaviour is identical.

## Structure
- Package user_lock_pkg holds:
  - the FSM state enum (IDLE, CHECK, DONE)
  - the default OWNER_ID constant
  - the default DATA_W constant
- Sub-module rr_arbiter:
  - inputs: req vector and rr_ptr
  - outputs: one-hot grant and encoded index
  - purely combinational
  - rr_ptr register lives in user_lock_arbiter

## Test plan
- Reset release with no req → data_out = 0, busy = 0, ack and err stay 0 for 10 cycles.
- req[1] with usr_id 2'h2 and wdata 8'hA5 → ack[1] one cycle high 2 edges later, data_out = 8'hA5, err = 0.
- req[3] with usr_id 2'h1 and wdata 8'h3C → err[3] pulse, data_out unchanged, viol_cnt +1 when the macro is set.
- All four req high, all ID 2'h2, data = index → grants in order 0, 1, 2, 3 at 3-cycle spacing, final data_out = 8'h03.
- rst asserted in CHECK state → no ack or err pulse, data_out = 0, state IDLE; the next request is served normally.
- 300 denied writes with the macro set → viol_cnt saturates at 8'hFF.
